sync_upsize_fifo: RTL and testbench

SYNC_UPSIZE_FIFO -- requirements
Module: sync_upsize_fifo

---
 rtl/fifo_pkg.sv | 18 +
 rtl/upsize_packer.sv | 61 ++++++
 rtl/sync_upsize_fifo.sv | 116 +++++++++++
 tb/tb_sync_upsize_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the width-upsizing FIFO: ratio and pack-slot placement.
package fifo_pkg;

  localparam int PACK_LSB_FIRST = 0;
  localparam int PACK_MSB_FIRST = 1;

  function automatic int calc_ratio(input int din_w, input int dout_w);
    return dout_w / din_w;
  endfunction

  // Bit offset of pack slot 'slot' inside the wide word.
  function automatic int slot_offset(input int msb_fifo, input int ratio,
                                     input int din_w, input int slot);
    if (msb_fifo == PACK_MSB_FIRST) return (ratio - 1 - slot) * din_w;
    return slot * din_w;
  endfunction

endpackage

// File: rtl/upsize_packer.sv
// Assembles RATIO narrow words into one wide word; also emits a zero-filled
// partial word on flush when the storage has a free slot.
module upsize_packer
  import fifo_pkg::*;
#(
  parameter int DIN_WIDTH  = 4,
  parameter int DOUT_WIDTH = 8,
  parameter int MSB_FIFO   = 1,
  parameter int CNT_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  flush,
  input  logic                  slot_free,
  output logic                  push,
  output logic [DOUT_WIDTH-1:0] word,
  output logic [CNT_W-1:0]      pack_cnt
);

  localparam int RATIO = calc_ratio(DIN_WIDTH, DOUT_WIDTH);

  logic [CNT_W-1:0]      pack_cnt_q, pack_cnt_d;
  logic [DOUT_WIDTH-1:0] buf_q, buf_d;
  logic [DOUT_WIDTH-1:0] ins, merged;
  logic                  complete, partial, flush_push;

  always_comb begin
    ins        = DOUT_WIDTH'(din) << slot_offset(MSB_FIFO, RATIO, DIN_WIDTH, int'(pack_cnt_q));
    merged     = wr ? (buf_q | ins) : buf_q;
    complete   = wr && (pack_cnt_q == CNT_W'(RATIO - 1));
    // Something is held once this edge's write (if any) is counted.
    partial    = wr || (pack_cnt_q != '0);
    flush_push = flush && slot_free && partial && !complete;
    push       = complete || flush_push;
    word       = merged;
    pack_cnt_d = pack_cnt_q;
    buf_d      = buf_q;
    if (push) begin
      pack_cnt_d = '0;
      buf_d      = '0;
    end else if (wr) begin
      pack_cnt_d = pack_cnt_q + CNT_W'(1);
      buf_d      = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      pack_cnt_q <= pack_cnt_d;
      buf_q      <= buf_d;
    end
  end

  assign pack_cnt = pack_cnt_q;

endmodule

// File: rtl/sync_upsize_fifo.sv
// Single-clock FWFT FIFO that packs DIN_WIDTH writes into DOUT_WIDTH words.
// Optional partial-word flush port enabled by SYNC_UPSIZE_FIFO_FLUSH_EN.
module sync_upsize_fifo
  import fifo_pkg::*;
#(
  parameter int DIN_WIDTH   = 4,
  parameter int DOUT_WIDTH  = 8,
  parameter int RADDR_WIDTH = 2,
  parameter int MSB_FIFO    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
`ifdef SYNC_UPSIZE_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  full,
  output logic                  almost_full,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [RADDR_WIDTH:0]  rd_count
);

  localparam int RATIO  = calc_ratio(DIN_WIDTH, DOUT_WIDTH);
  localparam int DEPTH  = 1 << RADDR_WIDTH;
  localparam int CNT_W  = $clog2(RATIO);
  localparam int FREE_W = RADDR_WIDTH + CNT_W + 2;

  logic [DOUT_WIDTH-1:0]  mem_q [DEPTH];
  logic [DOUT_WIDTH-1:0]  mem_d [DEPTH];
  logic [RADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DOUT_WIDTH-1:0]  dout_q, dout_d;
  logic [RADDR_WIDTH:0]   count;
  logic [RADDR_WIDTH-1:0] rd_idx_next;
  logic [FREE_W-1:0]      free;
  logic [CNT_W-1:0]       pack_cnt;
  logic [DOUT_WIDTH-1:0]  pk_word;
  logic                   pk_push, accept, pop, slot_free, flush_req;

`ifdef SYNC_UPSIZE_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign count     = wr_ptr_q - rd_ptr_q;
  assign accept    = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign slot_free = (count != (RADDR_WIDTH+1)'(DEPTH)) || pop;

  upsize_packer #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .MSB_FIFO   (MSB_FIFO),
    .CNT_W      (CNT_W)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (accept),
    .din       (din),
    .flush     (flush_req),
    .slot_free (slot_free),
    .push      (pk_push),
    .word      (pk_word),
    .pack_cnt  (pack_cnt)
  );

  // Free capacity in narrow words; flags depend on registered state only.
  assign free = (FREE_W'(DEPTH) - FREE_W'(count)) * FREE_W'(RATIO)
              + FREE_W'(RATIO - 1) - FREE_W'(pack_cnt);

  assign full         = (free == '0);
  assign almost_full  = (free == FREE_W'(1));
  assign empty        = (count == '0);
  assign almost_empty = (count <= (RADDR_WIDTH+1)'(1));
  assign rd_count     = count;
  assign dout         = dout_q;

  assign rd_idx_next = rd_ptr_q[RADDR_WIDTH-1:0] + RADDR_WIDTH'(1);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (pk_push) begin
      mem_d[wr_ptr_q[RADDR_WIDTH-1:0]] = pk_word;
      wr_ptr_d = wr_ptr_q + (RADDR_WIDTH+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (RADDR_WIDTH+1)'(1);
    // dout is a register mirroring the head, so a new word bypasses storage
    // when it becomes the head in the same edge.
    if (pk_push && (empty || (pop && count == (RADDR_WIDTH+1)'(1))))
      dout_d = pk_word;
    else if (pop && count > (RADDR_WIDTH+1)'(1))
      dout_d = mem_q[rd_idx_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: tb/tb_sync_upsize_fifo.sv
// Randomized + directed bench for sync_upsize_fifo against a queue-based model.
module tb_sync_upsize_fifo;

  localparam int DIN   = 4;
  localparam int DOUTW = 8;
  localparam int RAW   = 2;
  localparam int MSBF  = 1;
  localparam int RATIO = DOUTW / DIN;
  localparam int DEPTH = 1 << RAW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DIN-1:0]   din = '0;
  logic             wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic             full, almost_full, empty, almost_empty;
  logic [DOUTW-1:0] dout;
  logic [RAW:0]     rd_count;

  int n_chk = 0;
  int n_bad = 0;

  logic [DOUTW-1:0] mq[$];
  logic [DIN-1:0]   mp[$];
  logic [DOUTW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_upsize_fifo #(.DIN_WIDTH(DIN), .DOUT_WIDTH(DOUTW), .RADDR_WIDTH(RAW), .MSB_FIFO(MSBF)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
`ifdef SYNC_UPSIZE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .full(full), .almost_full(almost_full), .dout(dout), .rd_en(rd_en),
    .empty(empty), .almost_empty(almost_empty), .rd_count(rd_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_free();
    return (DEPTH - mq.size()) * RATIO + (RATIO - 1 - mp.size());
  endfunction

  // Arrival-ordered nibbles -> wide word; unfilled slots stay zero.
  function automatic logic [DOUTW-1:0] assemble();
    logic [DOUTW-1:0] w = '0;
    if (MSBF == 1) begin
      foreach (mp[i]) w = (w << DIN) | DOUTW'(mp[i]);
      w = w << (DIN * (RATIO - mp.size()));
    end else begin
      foreach (mp[i]) w = w | (DOUTW'(mp[i]) << (DIN * i));
    end
    return w;
  endfunction

  task automatic model_edge(input logic w, input logic [DIN-1:0] d, input logic r, input logic f);
    bit acc = w && (m_free() != 0);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mp.push_back(d);
      if (mp.size() == RATIO) begin
        mq.push_back(assemble());
        mp.delete();
      end
    end
    if (f && mp.size() > 0 && mq.size() < DEPTH) begin
      mq.push_back(assemble());
      mp.delete();
    end
    if (mq.size() > 0) m_dout = mq[0];
  endtask

  task automatic check_all();
    chk("empty", empty, mq.size() == 0);
    chk("almost_empty", almost_empty, mq.size() <= 1);
    chk("rd_count", rd_count, mq.size());
    chk("full", full, m_free() == 0);
    chk("almost_full", almost_full, m_free() == 1);
    chk("dout", dout, m_dout);
  endtask

  task automatic step(input logic w, input logic [DIN-1:0] d, input logic r, input logic f);
    check_all();
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk);
    model_edge(w, d, r, f);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic reset_low();
    #1 rst_n = 1'b0;
    mq.delete(); mp.delete(); m_dout = '0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_dout", dout, 0);
  endtask

  task automatic do_reset();
    reset_low();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // packing order
    step(1, 4'hA, 0, 0);
    chk("pack_empty_a", empty, 1);
    step(1, 4'hB, 0, 0);
    chk("pack_empty_b", empty, 0);
    chk("pack_dout", dout, (MSBF == 1) ? 8'hAB : 8'hBA);

    // fill, overflow ignored
    do_reset();
    for (int i = 0; i < 8; i++) step(1, DIN'(i), 0, 0);
    chk("fill_afull", almost_full, 1);
    chk("fill_count", rd_count, 4);
    chk("fill_full0", full, 0);
    step(1, 4'h8, 0, 0);
    chk("fill_full", full, 1);
    step(1, 4'h9, 0, 0);
    chk("fill_full_hold", full, 1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (MSBF == 1) ? {4'(2*i), 4'(2*i+1)} : {4'(2*i+1), 4'(2*i)};
      chk("fill_rd", dout, e);
      step(0, 0, 1, 0);
    end
    step(1, 4'hC, 0, 0);
    chk("fill_tail", dout, (MSBF == 1) ? 8'h8C : 8'hC8);

    // simultaneous completing write + read
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, DIN'(i), 0, 0);
    chk("sim_count0", rd_count, 2);
    chk("sim_dout0", dout, (MSBF == 1) ? 8'h12 : 8'h21);
    step(1, 4'h6, 1, 0);
    chk("sim_count1", rd_count, 2);
    chk("sim_dout1", dout, (MSBF == 1) ? 8'h34 : 8'h43);
    step(0, 0, 1, 0);
    chk("sim_dout2", dout, (MSBF == 1) ? 8'h56 : 8'h65);

    // reset mid-pack; first write lands on the first edge after release
    do_reset();
    step(1, 4'h3, 0, 0);
    reset_low();
    wr_en = 1'b1; din = 4'h1;
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_edge(1, 4'h1, 0, 0);
    @(negedge clk);
    wr_en = 1'b0;
    step(1, 4'h2, 0, 0);
    chk("midpack_dout", dout, (MSBF == 1) ? 8'h12 : 8'h21);

`ifdef SYNC_UPSIZE_FIFO_FLUSH_EN
    do_reset();
    step(1, 4'h5, 0, 0);
    step(0, 0, 0, 1);
    chk("flush_dout", dout, (MSBF == 1) ? 8'h50 : 8'h05);
    chk("flush_count", rd_count, 1);
    chk("flush_pcnt", dut.u_pack.pack_cnt_q, 0);
    step(0, 0, 0, 1);
    chk("flush_noop", rd_count, 1);
`endif

    // random traffic, write-heavy then read-heavy phases
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wp = (i % 600 < 300) ? 75 : 35;
      logic f = 1'b0;
`ifdef SYNC_UPSIZE_FIFO_FLUSH_EN
      f = ($urandom_range(0, 15) == 0);
`endif
      step($urandom_range(0, 99) < wp, DIN'($urandom), $urandom_range(0, 99) < (100 - wp), f);
      if (i == 1500) do_reset();
    end
    check_all();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
